cb_updown_counter: RTL and testbench

- Registered, loadable, cascadable modulo-N up/down counter.
- Sequential counterpart to the combinational 4-bit carry/borrow slice in the SC primitive library: this block owns the count state and drives the next-state computation.
- Direction polarity matches the slice: CON=1 counts up, CON=0 counts down.
- Cascade inputs and outputs let several instances chain into wider counters under one clock.

---
 rtl/cb_updown_counter.sv | 98 +++++++++
 tb/tb_cb_updown_counter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/cb_updown_counter.sv
// cb_updown_counter: registered, loadable, cascadable modulo-MODULUS up/down
// counter. CON=1 counts up and CON=0 counts down. CO is a combinational
// carry/borrow out that feeds the CI of the next stage. TC is a one-cycle
// registered pulse that marks a wrap.
module cb_updown_counter #(
    parameter int unsigned     WIDTH   = 4,
    parameter longint unsigned MODULUS = 16,
    parameter longint unsigned INIT    = 0
) (
    input  logic             CK,
    input  logic             CD,
    input  logic             CE,
    input  logic             CI,
    input  logic             CON,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             CO,
    output logic             TC
);

    // Comparisons use WIDTH+1 bits so that MODULUS == 2**WIDTH can be represented.
    localparam logic [WIDTH:0]   ONE_EXT = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH:0]   MOD_EXT = MODULUS[WIDTH:0];
    localparam logic [WIDTH:0]   TOP_EXT = MOD_EXT - ONE_EXT;
    localparam logic [WIDTH-1:0] TOP_Q   = TOP_EXT[WIDTH-1:0];
    localparam logic [WIDTH-1:0] INIT_Q  = INIT[WIDTH-1:0];

    logic [WIDTH-1:0] q_q, q_d;
    logic             tc_q, tc_d;

    logic [WIDTH:0]   q_ext;
    logic [WIDTH-1:0] q_inc;
    logic [WIDTH-1:0] q_dec;
    logic             at_top;
    logic             at_zero;
    logic             out_of_range;

    // Decode the terminal states and the +/-1 neighbours of the current count.
    // A value at or above MODULUS-1 counts as the up terminal, so a value that
    // was loaded out of range wraps to 0 on the next up step.
    assign q_ext        = {1'b0, q_q};
    assign q_inc        = WIDTH'(q_ext + ONE_EXT);
    assign q_dec        = WIDTH'(q_ext - ONE_EXT);
    assign at_top       = (q_ext >= TOP_EXT);
    assign at_zero      = (q_q == '0);
    assign out_of_range = (q_ext >= MOD_EXT);

    // The cascade output does not depend on CE or LOAD. It stays valid during reset.
    assign CO = CI & (CON ? at_top : at_zero);

    // Next-state logic. Priority order is CE, then LOAD, then CI, then direction.
    always_comb begin
        // NOTE: defaults come first so that every path assigns every output. Without them a latch would be inferred.
        q_d  = q_q;
        tc_d = 1'b0;
        if (CE) begin
            if (LOAD) begin
                q_d = D;
            end else if (CI) begin
                if (CON) begin
                    if (at_top) begin
                        q_d  = '0;
                        tc_d = 1'b1;
                    end else begin
                        q_d = q_inc;
                    end
                end else begin
                    if (at_zero) begin
                        q_d  = TOP_Q;
                        tc_d = 1'b1;
                    end else if (out_of_range) begin
                        // An out-of-range value returns to the top of the range. This is not a wrap, so TC stays low.
                        q_d = TOP_Q;
                    end else begin
                        q_d = q_dec;
                    end
                end
            end
        end
    end

    // State register with an asynchronous clear to INIT.
    always_ff @(posedge CK or posedge CD) begin
        // NOTE: the clear is asynchronous, so CD must be in the sensitivity list. Sequential state uses non-blocking assignments only.
        if (CD) begin
            q_q  <= INIT_Q;
            tc_q <= 1'b0;
        end else begin
            q_q  <= q_d;
            tc_q <= tc_d;
        end
    end

    assign Q  = q_q;
    assign TC = tc_q;

endmodule

// File: tb/tb_cb_updown_counter.sv
// Directed testbench for cb_updown_counter. Expected values are computed by hand.
module tb_cb_updown_counter;

    logic       clk;
    logic       cd, ce, ci, con, load;
    logic [3:0] d, d_lo, d_hi;

    logic [3:0] q16, q10, q_lo, q_hi;
    logic       tc16, tc10, tc_lo, tc_hi;
    logic       co16, co10, co_lo, co_hi;

    int n_vec = 0;
    int n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    cb_updown_counter #(.WIDTH(4), .MODULUS(16), .INIT(5)) u16 (
        .CK(clk), .CD(cd), .CE(ce), .CI(ci), .CON(con), .LOAD(load),
        .D(d), .Q(q16), .CO(co16), .TC(tc16)
    );

    cb_updown_counter #(.WIDTH(4), .MODULUS(10), .INIT(0)) u10 (
        .CK(clk), .CD(cd), .CE(ce), .CI(ci), .CON(con), .LOAD(load),
        .D(d), .Q(q10), .CO(co10), .TC(tc10)
    );

    cb_updown_counter #(.WIDTH(4), .MODULUS(16), .INIT(0)) u_lo (
        .CK(clk), .CD(cd), .CE(ce), .CI(1'b1), .CON(con), .LOAD(load),
        .D(d_lo), .Q(q_lo), .CO(co_lo), .TC(tc_lo)
    );

    cb_updown_counter #(.WIDTH(4), .MODULUS(16), .INIT(0)) u_hi (
        .CK(clk), .CD(cd), .CE(ce), .CI(co_lo), .CON(con), .LOAD(load),
        .D(d_hi), .Q(q_hi), .CO(co_hi), .TC(tc_hi)
    );

    // Wait for one rising edge, then settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        cd = 1'b1; ce = 1'b0; ci = 1'b1; con = 1'b0; load = 1'b0;
        d = 4'd0; d_lo = 4'd0; d_hi = 4'd0;
        #3;
        n_vec++; if (q16 !== 4'd5) begin n_err++; $display("FAIL reset_q: got %0d want 5", q16); end
        n_vec++; if (tc16 !== 1'b0) begin n_err++; $display("FAIL reset_tc: got %b want 0", tc16); end
        n_vec++; if (co10 !== 1'b1) begin n_err++; $display("FAIL reset_co_down_zero: got %b want 1", co10); end
        n_vec++; if (co16 !== 1'b0) begin n_err++; $display("FAIL reset_co_q5: got %b want 0", co16); end
        tick();
        tick();
        n_vec++; if (q16 !== 4'd5) begin n_err++; $display("FAIL reset_hold_q: got %0d want 5", q16); end
        cd = 1'b0; ce = 1'b1; con = 1'b1;
        tick();
        n_vec++; if (q16 !== 4'd6) begin n_err++; $display("FAIL release_q6: got %0d want 6", q16); end
        tick();
        n_vec++; if (q16 !== 4'd7) begin n_err++; $display("FAIL release_q7: got %0d want 7", q16); end
        tick();
        n_vec++; if (q16 !== 4'd8) begin n_err++; $display("FAIL release_q8: got %0d want 8", q16); end
        // Wrap u16 so that TC is high, then assert the clear mid-cycle.
        load = 1'b1; d = 4'd15;
        tick();
        load = 1'b0;
        tick();
        n_vec++; if (q16 !== 4'd0 || tc16 !== 1'b1) begin n_err++; $display("FAIL full_mod_wrap: got q=%0d tc=%b want q=0 tc=1", q16, tc16); end
        #3 cd = 1'b1;
        #1;
        n_vec++; if (q16 !== 4'd5 || tc16 !== 1'b0) begin n_err++; $display("FAIL async_clear: got q=%0d tc=%b want q=5 tc=0", q16, tc16); end
        #1 cd = 1'b0;
        tick();
        n_vec++; if (q16 !== 4'd6) begin n_err++; $display("FAIL first_edge_after_clear: got %0d want 6", q16); end
    endtask

    task automatic test_up_wrap();
        ce = 1'b1; ci = 1'b1; con = 1'b1; load = 1'b1; d = 4'd8;
        tick();
        load = 1'b0;
        n_vec++; if (q10 !== 4'd8) begin n_err++; $display("FAIL up_load8: got %0d want 8", q10); end
        tick();
        n_vec++; if (q10 !== 4'd9 || co10 !== 1'b1 || tc10 !== 1'b0) begin n_err++; $display("FAIL up_q9_co: got q=%0d co=%b tc=%b want q=9 co=1 tc=0", q10, co10, tc10); end
        tick();
        n_vec++; if (q10 !== 4'd0 || tc10 !== 1'b1) begin n_err++; $display("FAIL up_wrap: got q=%0d tc=%b want q=0 tc=1", q10, tc10); end
        tick();
        n_vec++; if (q10 !== 4'd1 || tc10 !== 1'b0) begin n_err++; $display("FAIL up_after_wrap: got q=%0d tc=%b want q=1 tc=0", q10, tc10); end
    endtask

    task automatic test_down_reverse();
        load = 1'b1; d = 4'd1;
        tick();
        load = 1'b0; con = 1'b0;
        tick();
        n_vec++; if (q10 !== 4'd0 || co10 !== 1'b1 || tc10 !== 1'b0) begin n_err++; $display("FAIL down_q0_co: got q=%0d co=%b tc=%b want q=0 co=1 tc=0", q10, co10, tc10); end
        tick();
        n_vec++; if (q10 !== 4'd9 || tc10 !== 1'b1) begin n_err++; $display("FAIL down_wrap: got q=%0d tc=%b want q=9 tc=1", q10, tc10); end
        con = 1'b1;
        #1;
        n_vec++; if (co10 !== 1'b1) begin n_err++; $display("FAIL reverse_co: got %b want 1", co10); end
        tick();
        n_vec++; if (q10 !== 4'd0 || tc10 !== 1'b1) begin n_err++; $display("FAIL reverse_wrap: got q=%0d tc=%b want q=0 tc=1", q10, tc10); end
    endtask

    task automatic test_priority();
        ce = 1'b0; load = 1'b1; d = 4'd3;
        tick();
        n_vec++; if (q10 !== 4'd0 || tc10 !== 1'b0) begin n_err++; $display("FAIL ce_low_hold: got q=%0d tc=%b want q=0 tc=0", q10, tc10); end
        ce = 1'b1; ci = 1'b1; con = 1'b1;
        tick();
        n_vec++; if (q10 !== 4'd3 || tc10 !== 1'b0) begin n_err++; $display("FAIL load_wins: got q=%0d tc=%b want q=3 tc=0", q10, tc10); end
        d = 4'd9;
        tick();
        ci = 1'b0; load = 1'b0;
        tick();
        n_vec++; if (q10 !== 4'd9 || co10 !== 1'b0) begin n_err++; $display("FAIL ci_low_hold: got q=%0d co=%b want q=9 co=0", q10, co10); end
        ci = 1'b1;
    endtask

    task automatic test_out_of_range();
        con = 1'b1; load = 1'b1; d = 4'd12;
        tick();
        load = 1'b0;
        n_vec++; if (q10 !== 4'd12 || co10 !== 1'b1) begin n_err++; $display("FAIL oor_load: got q=%0d co=%b want q=12 co=1", q10, co10); end
        tick();
        n_vec++; if (q10 !== 4'd0 || tc10 !== 1'b1) begin n_err++; $display("FAIL oor_up: got q=%0d tc=%b want q=0 tc=1", q10, tc10); end
        load = 1'b1;
        tick();
        load = 1'b0; con = 1'b0;
        #1;
        n_vec++; if (co10 !== 1'b0) begin n_err++; $display("FAIL oor_co_down: got %b want 0", co10); end
        tick();
        n_vec++; if (q10 !== 4'd9 || tc10 !== 1'b0) begin n_err++; $display("FAIL oor_down: got q=%0d tc=%b want q=9 tc=0", q10, tc10); end
    endtask

    task automatic test_cascade();
        ce = 1'b1; con = 1'b1; load = 1'b1; d_hi = 4'h0; d_lo = 4'hF;
        tick();
        load = 1'b0;
        tick();
        n_vec++; if ({q_hi, q_lo} !== 8'h10 || tc_lo !== 1'b1 || tc_hi !== 1'b0) begin n_err++; $display("FAIL casc_0f_up: got %h tc_lo=%b tc_hi=%b want 10 1 0", {q_hi, q_lo}, tc_lo, tc_hi); end
        tick();
        n_vec++; if ({q_hi, q_lo} !== 8'h11 || tc_hi !== 1'b0) begin n_err++; $display("FAIL casc_10_up: got %h tc_hi=%b want 11 0", {q_hi, q_lo}, tc_hi); end
        load = 1'b1; d_hi = 4'hF; d_lo = 4'hF;
        tick();
        load = 1'b0;
        n_vec++; if (co_hi !== 1'b1) begin n_err++; $display("FAIL casc_co_hi: got %b want 1", co_hi); end
        tick();
        n_vec++; if ({q_hi, q_lo} !== 8'h00 || tc_lo !== 1'b1 || tc_hi !== 1'b1) begin n_err++; $display("FAIL casc_ff_up: got %h tc_lo=%b tc_hi=%b want 00 1 1", {q_hi, q_lo}, tc_lo, tc_hi); end
        con = 1'b0;
        tick();
        n_vec++; if ({q_hi, q_lo} !== 8'hFF || tc_lo !== 1'b1 || tc_hi !== 1'b1) begin n_err++; $display("FAIL casc_00_down: got %h tc_lo=%b tc_hi=%b want ff 1 1", {q_hi, q_lo}, tc_lo, tc_hi); end
    endtask

    initial begin
        test_reset();
        test_up_wrap();
        test_down_reverse();
        test_priority();
        test_out_of_range();
        test_cascade();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
